// File: rtl/seg7_scan_multich_if.sv
// Load/status handshake between the simulator core and the 7-segment scan driver.
// The core (master) presents sign/magnitude snapshots and pulses load; the driver
// (slave) reports busy while converting and pulses done when the display updates.
interface seg7_scan_multich_if #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 7
);
    logic                   load;
    logic [NUM_CH-1:0]      ch_sign;
    logic [NUM_CH*CH_W-1:0] ch_mag;
    logic                   busy;
    logic                   done;

    modport master (output load, ch_sign, ch_mag, input busy, done);
    modport slave  (input load, ch_sign, ch_mag, output busy, done);
endinterface

// File: rtl/seg7_scan_multich.sv
// Multiplexed 7-segment scan driver for NUM_CH signed channels of DIG_PER_CH
// decimal digits each, separated by one blank digit. Binary magnitudes are turned
// into BCD by a sequential double-dabble converter, one channel at a time, into a
// shadow bank that is committed to the display registers in a single cycle.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank zero digits above the most
// significant non-zero digit of each channel; the ones digit always shows).
module seg7_scan_multich #(
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 7,
    parameter int DIG_PER_CH = 2,
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic                  clk100mhz,
    input  logic                  rst_n,
    seg7_scan_multich_if.slave    bus,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int TICKS     = CLK_HZ / REFRESH_HZ;
    localparam int TMR_W     = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STEP_W    = (CH_W > 1) ? $clog2(CH_W) : 1;
    localparam int BCD_W     = 4 * DIG_PER_CH;
    localparam int SR_W      = BCD_W + CH_W;
    localparam int SLOT      = DIG_PER_CH + 1;
    localparam int OVF_LIMIT = 10 ** DIG_PER_CH;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b111_1110;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, NEXT, COMMIT} state_t;

    // Control
    state_t                state_q;
    logic [CH_IDX_W-1:0]   ch_q;
    logic [STEP_W-1:0]     step_q;
    logic                  busy_q;
    logic                  done_q;

    // Conversion datapath
    logic [NUM_CH*CH_W-1:0] snap_mag_q;
    logic [NUM_CH-1:0]      snap_sign_q;
    logic [SR_W-1:0]        sr_q;
    logic [SR_W-1:0]        sr_adj;
    logic [SR_W-1:0]        sr_d;
    logic [BCD_W-1:0]       shadow_bcd_q [NUM_CH];
    logic [NUM_CH-1:0]      shadow_ovf_q;
    logic [CH_W-1:0]        cur_mag;
    logic [CH_W-1:0]        next_mag;
    logic                   cur_ovf;

    // Committed display contents
    logic [BCD_W-1:0]       disp_bcd_q [NUM_CH];
    logic [NUM_CH-1:0]      disp_ovf_q;
    logic [NUM_CH-1:0]      disp_sign_q;

    // Scan
    logic [TMR_W-1:0]       timer_q;
    logic [DIG_W-1:0]       digit_q;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [3:0]             nib;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'b000_0001;
            4'd1:    glyph = 7'b100_1111;
            4'd2:    glyph = 7'b001_0010;
            4'd3:    glyph = 7'b000_0110;
            4'd4:    glyph = 7'b100_1100;
            4'd5:    glyph = 7'b010_0100;
            4'd6:    glyph = 7'b010_0000;
            4'd7:    glyph = 7'b000_1111;
            4'd8:    glyph = 7'b000_0000;
            4'd9:    glyph = 7'b000_0100;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    // True when digit k and every digit above it are zero (never for the ones digit).
    function automatic logic lz_blank(input logic [BCD_W-1:0] bcd, input int k);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < DIG_PER_CH; j++) begin
            if (j >= k && bcd[4*j +: 4] != 4'd0) upper_zero = 1'b0;
        end
        return (k != 0) && upper_zero;
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIG_PER_CH; i++) begin
            if (sr_q[CH_W + 4*i +: 4] >= 4'd5)
                sr_adj[CH_W + 4*i +: 4] = sr_q[CH_W + 4*i +: 4] + 4'd3;
        end
        sr_d = sr_adj << 1;
    end

    // Magnitudes of the channel being finished and the one about to start.
    always_comb begin
        cur_mag  = snap_mag_q[int'(ch_q)*CH_W +: CH_W];
        next_mag = '0;
        if (int'(ch_q) < NUM_CH - 1)
            next_mag = snap_mag_q[(int'(ch_q) + 1)*CH_W +: CH_W];
        cur_ovf = (int'(cur_mag) >= OVF_LIMIT);
    end

    // Conversion sequencer: IDLE -> (SHIFT x CH_W -> NEXT) x NUM_CH -> COMMIT.
    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        busy_q  <= 1'b1;
                        ch_q    <= '0;
                        step_q  <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (step_q == STEP_W'(CH_W - 1)) begin
                        step_q  <= '0;
                        state_q <= NEXT;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                NEXT: begin
                    if (ch_q == CH_IDX_W'(NUM_CH - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end else begin
                        ch_q    <= ch_q + CH_IDX_W'(1);
                        state_q <= SHIFT;
                    end
                end
                COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Snapshot, shift register and shadow bank follow the sequencer.
    // NOTE: these are pure datapath storage, always written before being read, so
    // they carry no reset; only the committed display registers are cleared.
    always_ff @(posedge clk100mhz) begin
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    snap_mag_q  <= bus.ch_mag;
                    snap_sign_q <= bus.ch_sign;
                    sr_q        <= {{BCD_W{1'b0}}, bus.ch_mag[CH_W-1:0]};
                end
            end
            SHIFT: sr_q <= sr_d;
            NEXT: begin
                shadow_bcd_q[ch_q] <= sr_q[SR_W-1 -: BCD_W];
                shadow_ovf_q[ch_q] <= cur_ovf;
                sr_q               <= {{BCD_W{1'b0}}, next_mag};
            end
            default: ;
        endcase
    end

    // Atomic copy of the shadow bank and signs into the display registers.
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) disp_bcd_q[c] <= '0;
            disp_ovf_q  <= '0;
            disp_sign_q <= '0;
        end else if (state_q == COMMIT) begin
            for (int c = 0; c < NUM_CH; c++) disp_bcd_q[c] <= shadow_bcd_q[c];
            disp_ovf_q  <= shadow_ovf_q;
            disp_sign_q <= snap_sign_q;
        end
    end

    // Decode the currently scanned digit into anode, segment and dp values.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        nib   = '0;
        an_d  = ~(NUM_DIGITS'(1) << digit_q);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < DIG_PER_CH; k++) begin
                if (int'(digit_q) == c*SLOT + k) begin
                    nib = disp_bcd_q[c][4*k +: 4];
                    if (disp_ovf_q[c])
                        seg_d = SEG_DASH;
                    else if (LZ_BLANK && lz_blank(disp_bcd_q[c], k))
                        seg_d = SEG_BLANK;
                    else
                        seg_d = glyph(nib);
                    if (k == 0 && disp_sign_q[c]) dp_d = 1'b0;
                end
            end
        end
    end

    // Dwell timer, digit counter and registered pin drivers (an/seg/dp switch together).
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            digit_q <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            if (timer_q == TMR_W'(TICKS - 1)) begin
                timer_q <= '0;
                digit_q <= (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
            end else begin
                timer_q <= timer_q + TMR_W'(1);
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;

endmodule
